// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

    localparam int CNT_W  = 32;
    localparam int MAX_IN = 4;
    localparam int IDX_W  = 2;

    // Round-robin pick: first set bit of valid searching from last+1 upward,
    // wrapping at n. Returns a one-hot vector, or zero when nothing is valid.
    function automatic logic [MAX_IN-1:0] rr_pick(input logic [MAX_IN-1:0] valid,
                                                  input logic [IDX_W-1:0]  last,
                                                  input int unsigned       n);
        logic [MAX_IN-1:0] res;
        logic              found;
        int unsigned       idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_IN; k++) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                if (!found && valid[idx[IDX_W-1:0]]) begin
                    res[idx[IDX_W-1:0]] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_out_stage.sv
// Two-entry register FIFO between the arbiter mux and the downstream MAC.
// Accepts a new beat whenever not full; one cycle from push to m_valid.
module axis_out_stage
    import axis_arb_pkg::*;
#(
    parameter int DW = 512,
    parameter int KW = 64,
    parameter int UW = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [KW-1:0] s_keep,
    input  logic [UW-1:0] s_user,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [KW-1:0] m_keep,
    output logic [UW-1:0] m_user,
    output logic          m_last
);

    localparam int WW = DW + KW + UW + 1;

    logic [WW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          push, pop;

    assign s_ready = (cnt_q != 2'd2);
    assign m_valid = (cnt_q != 2'd0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    assign {m_data, m_keep, m_user, m_last} = mem_q[rd_q];

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    // Beat storage needs no reset: it is qualified by the count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {s_data, s_keep, s_user, s_last};
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI stream (MAC TX path)
// between NUM_IN sources. A grant is held from first beat to tlast.
// Optional per-input packet counters: define AXIS_ARB_PKT_COUNT_EN.
//
// state   | meaning
// S_IDLE  | no owner; one cycle to pick the next input (if enable)
// S_GRANT | grant owns the output until its tlast beat is accepted
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DW     = 512,
    parameter int KW     = 64,
    parameter int UW     = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [NUM_IN*DW-1:0]    in_tdata,
    input  logic [NUM_IN*KW-1:0]    in_tkeep,
    input  logic [NUM_IN*UW-1:0]    in_tuser,
    input  logic [NUM_IN-1:0]       in_tlast,
    input  logic [NUM_IN-1:0]       in_tvalid,
    output logic [NUM_IN-1:0]       in_tready,
    output logic [DW-1:0]           axis_out_tdata,
    output logic [KW-1:0]           axis_out_tkeep,
    output logic [UW-1:0]           axis_out_tuser,
    output logic                    axis_out_tlast,
    output logic                    axis_out_tvalid,
    input  logic                    axis_out_tready,
    output logic [NUM_IN-1:0]       grant,
    output logic                    busy,
    output logic [NUM_IN*CNT_W-1:0] pkt_count
);

    arb_state_e        state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [MAX_IN-1:0] valid_pad;
    logic [MAX_IN-1:0] pick;
    logic              unused_pick;
    logic [IDX_W-1:0]  gidx;
    logic              sel_valid, sel_last;
    logic [DW-1:0]     sel_data;
    logic [KW-1:0]     sel_keep;
    logic [UW-1:0]     sel_user;
    logic              stage_valid, stage_in_ready;
    logic              beat_acc;

    // Round-robin candidate from the current valids, starting after last owner.
    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_IN-1:0]  = in_tvalid;
        pick                   = rr_pick(valid_pad, last_q, NUM_IN);
    end

    assign unused_pick = ^pick;

    // Mux the granted input onto the stage input.
    always_comb begin
        gidx      = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) begin
                gidx      = IDX_W'(i);
                sel_valid = in_tvalid[i];
                sel_last  = in_tlast[i];
                sel_data  = in_tdata[i*DW +: DW];
                sel_keep  = in_tkeep[i*KW +: KW];
                sel_user  = in_tuser[i*UW +: UW];
            end
        end
    end

    // Next-state, grant and handshake logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        in_tready   = '0;
        stage_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && (|in_tvalid)) begin
                    grant_d = pick[NUM_IN-1:0];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                in_tready   = grant_q & {NUM_IN{stage_in_ready}};
                stage_valid = sel_valid;
                if (sel_valid && stage_in_ready && sel_last) begin
                    last_d  = gidx;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; after reset input 0 is first in line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign beat_acc = stage_valid & stage_in_ready;

    axis_out_stage #(
        .DW (DW),
        .KW (KW),
        .UW (UW)
    ) u_out_stage (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (stage_valid),
        .s_ready (stage_in_ready),
        .s_data  (sel_data),
        .s_keep  (sel_keep),
        .s_user  (sel_user),
        .s_last  (sel_last),
        .m_valid (axis_out_tvalid),
        .m_ready (axis_out_tready),
        .m_data  (axis_out_tdata),
        .m_keep  (axis_out_tkeep),
        .m_user  (axis_out_tuser),
        .m_last  (axis_out_tlast)
    );

    assign grant = grant_q;
    assign busy  = (state_q == S_GRANT) | axis_out_tvalid;

`ifdef AXIS_ARB_PKT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_IN];

    // Count packets whose tlast beat was accepted; wraps naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (!resetn)
                cnt_q[i] <= '0;
            else if (beat_acc && sel_last && grant_q[i])
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_IN; i++)
            pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: packets are queued per source, a
// packet-level round-robin model predicts the output beat order, and a
// monitor compares every output handshake against that prediction.
module tb_axis_pkt_arbiter;

    localparam int NUM_IN = 2;
    localparam int DW     = 64;
    localparam int KW     = 8;
    localparam int UW     = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        logic          first;
    } beat_t;

    logic                 clk;
    logic                 resetn;
    logic                 enable;
    logic [NUM_IN*DW-1:0] in_tdata;
    logic [NUM_IN*KW-1:0] in_tkeep;
    logic [NUM_IN*UW-1:0] in_tuser;
    logic [NUM_IN-1:0]    in_tlast;
    logic [NUM_IN-1:0]    in_tvalid;
    logic [NUM_IN-1:0]    in_tready;
    logic [DW-1:0]        axis_out_tdata;
    logic [KW-1:0]        axis_out_tkeep;
    logic [UW-1:0]        axis_out_tuser;
    logic                 axis_out_tlast;
    logic                 axis_out_tvalid;
    logic                 axis_out_tready;
    logic [NUM_IN-1:0]    grant;
    logic                 busy;
    logic [NUM_IN*32-1:0] pkt_count;

    axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DW(DW), .KW(KW), .UW(UW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .enable          (enable),
        .in_tdata        (in_tdata),
        .in_tkeep        (in_tkeep),
        .in_tuser        (in_tuser),
        .in_tlast        (in_tlast),
        .in_tvalid       (in_tvalid),
        .in_tready       (in_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tuser  (axis_out_tuser),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .grant           (grant),
        .busy            (busy),
        .pkt_count       (pkt_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    beat_t       dq [NUM_IN][$];
    beat_t       pm [NUM_IN][$];
    beat_t       exp_q [$];
    int          stamps [$];
    int          m_last;
    int unsigned cnt_m [NUM_IN];
    logic [NUM_IN-1:0] acc;
    logic [NUM_IN-1:0] held;
    bit          gaps_en;
    int          rdy_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run time exceeded, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Present the head beat of every source queue.
    task automatic drive_all();
        beat_t b;
        for (int i = 0; i < NUM_IN; i++) begin
            if (dq[i].size() > 0) begin
                b = dq[i][0];
                in_tvalid[i] = held[i] | b.first | !gaps_en | ($urandom_range(0, 3) != 0);
                in_tdata[i*DW +: DW] = b.d;
                in_tkeep[i*KW +: KW] = b.k;
                in_tuser[i*UW +: UW] = b.u;
                in_tlast[i]          = b.l;
            end else begin
                in_tvalid[i] = 1'b0;
                in_tlast[i]  = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        acc = in_tvalid & in_tready;
    end

    // Source driver: retire accepted beats, then present the next ones.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) axis_out_tready = ($urandom_range(0, 9) < 7);
        held = in_tvalid & ~acc;
        for (int i = 0; i < NUM_IN; i++)
            if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        drive_all();
    end

    // Monitor: every output handshake must match the head of the expectation.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (resetn && axis_out_tvalid && axis_out_tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_beat: got unexpected beat %0h, required none", axis_out_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {axis_out_tdata, axis_out_tkeep, axis_out_tuser, axis_out_tlast},
                    {e.d, e.k, e.u, e.l});
                stamps.push_back(cyc);
            end
        end
    end

    task automatic enqueue(input int src, input int len, input logic [DW-1:0] base, input bit rnd);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d     = rnd ? {$urandom, $urandom} : base + DW'(j);
            b.k     = rnd ? KW'($urandom) : '1;
            b.u     = rnd ? UW'($urandom) : '0;
            b.l     = (j == len - 1);
            b.first = (j == 0);
            dq[src].push_back(b);
            pm[src].push_back(b);
        end
    endtask

    // Packet-level round robin over whatever the model holds as pending.
    task automatic schedule();
        int  s;
        bit  found;
        beat_t b;
        forever begin
            found = 0;
            s     = 0;
            for (int k = 1; k <= NUM_IN; k++) begin
                if (!found && pm[(m_last + k) % NUM_IN].size() > 0) begin
                    s     = (m_last + k) % NUM_IN;
                    found = 1;
                end
            end
            if (!found) break;
            do begin
                b = pm[s].pop_front();
                exp_q.push_back(b);
            end while (!b.l);
            m_last = s;
            cnt_m[s]++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_IN; i++) begin
            dq[i].delete();
            pm[i].delete();
            cnt_m[i] = 0;
        end
        exp_q.delete();
        stamps.delete();
        m_last    = NUM_IN - 1;
        in_tvalid = '0;
        in_tlast  = '0;
        held      = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic chk_cnt(input string name);
        for (int i = 0; i < NUM_IN; i++) begin
`ifdef AXIS_ARB_PKT_COUNT_EN
            chk(name, 128'(pkt_count[i*32 +: 32]), 128'(cnt_m[i]));
`else
            chk(name, 128'(pkt_count[i*32 +: 32]), 128'(0));
`endif
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int  n;
        bit  pend;
        n = 0;
        forever begin
            @(negedge clk);
            pend = (exp_q.size() != 0) || busy;
            for (int i = 0; i < NUM_IN; i++) if (dq[i].size() != 0) pend = 1;
            if (!pend || n >= budget) break;
            n++;
        end
        @(negedge clk);
        chk(name, 128'(n >= budget), 128'(0));
        if (n >= budget) clear_model();
    endtask

    task automatic wait_grant(input string name, input logic [NUM_IN-1:0] want, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < budget);
        chk(name, 128'(grant), 128'(want));
    endtask

    initial begin
        int  bad;
        bit  seen_full;
        int  pat [4] = '{1, 0, 0, 1};

        resetn          = 1'b0;
        enable          = 1'b1;
        in_tdata        = '0;
        in_tkeep        = '0;
        in_tuser        = '0;
        in_tlast        = '0;
        in_tvalid       = '0;
        axis_out_tready = 1'b1;
        gaps_en         = 0;
        rdy_mode        = 0;
        acc             = '0;
        clear_model();
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_in_tready", 128'(in_tready), 128'(0));
        chk("rst_out_tvalid", 128'(axis_out_tvalid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk_cnt("rst_pkt_count");

        // Single source, 4-beat packet, exact timing.
        @(posedge clk);
        #2;
        enqueue(0, 4, DW'(1), 0);
        schedule();
        drive_all();
        @(negedge clk);
        chk("arb_cycle_grant", 128'(grant), 128'(0));
        chk("arb_cycle_tready", 128'(in_tready), 128'(0));
        @(negedge clk);
        chk("single_grant", 128'(grant), 128'(2'b01));
        chk("single_tready", 128'(in_tready), 128'(2'b01));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("single_out_valid", 128'(axis_out_tvalid), 128'(1));
            chk("single_out_data", 128'(axis_out_tdata), 128'(k));
            chk("single_out_last", 128'(axis_out_tlast), 128'(k == 4));
            if (k == 4) chk("single_grant_release", 128'(grant), 128'(0));
        end
        @(negedge clk);
        chk("single_busy_drop", 128'(busy), 128'(0));
        wait_drain("single_drain", 50);
        chk_cnt("single_pkt_count");

        // Contention: 3 packets on in0, 2 on in1, 3 beats each.
        do_reset();
        for (int p = 0; p < 3; p++) enqueue(0, 3, DW'(16'h0100 + p * 16), 0);
        for (int p = 0; p < 2; p++) enqueue(1, 3, DW'(16'h1100 + p * 16), 0);
        schedule();
        wait_drain("cont_drain", 200);
        chk("cont_beats", 128'(stamps.size()), 128'(15));
        if (stamps.size() == 15)
            chk("cont_span", 128'(stamps[14] - stamps[0]), 128'(18));
        chk_cnt("cont_pkt_count");

        // Backpressure on a 5-beat packet.
        do_reset();
        rdy_mode = 2;
        enqueue(0, 5, DW'(16'h0500), 0);
        schedule();
        wait_grant("bp_grant", 2'b01, 20);
        seen_full = 0;
        for (int p = 0; p < 4; p++) begin
            @(posedge clk);
            #2;
            axis_out_tready = pat[p][0];
            @(negedge clk);
            if (grant[0] && !in_tready[0]) seen_full = 1;
        end
        rdy_mode        = 0;
        axis_out_tready = 1'b1;
        chk("bp_stage_full", 128'(seen_full), 128'(1));
        wait_drain("bp_drain", 100);
        chk("bp_beats", 128'(stamps.size()), 128'(5));

        // enable dropped mid-packet on input 1.
        do_reset();
        enqueue(1, 4, DW'(16'h2200), 0);
        schedule();
        wait_grant("en_grant1", 2'b10, 20);
        @(posedge clk);
        #2;
        enable = 1'b0;
        enqueue(0, 2, DW'(16'h3300), 0);
        enqueue(1, 2, DW'(16'h3400), 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (!busy && grant != '0) bad++;
        end
        chk("en_grant_held_idle", 128'(grant), 128'(0));
        chk("en_no_regrant", 128'(bad), 128'(0));
        chk("en_busy_drained", 128'(busy), 128'(0));
        chk("en_pkt_done", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #2;
        enable = 1'b1;
        schedule();
        wait_grant("en_resume_grant", 2'b01, 20);
        wait_drain("en_drain", 100);
        chk_cnt("en_pkt_count");

        // Reset on the second beat of an input-1 packet.
        do_reset();
        enqueue(0, 2, DW'(16'h4400), 0);
        schedule();
        wait_drain("rm_pre_drain", 50);
        enqueue(1, 4, DW'(16'h4500), 0);
        schedule();
        wait_grant("rm_grant1", 2'b10, 20);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #2;
        clear_model();
        @(negedge clk);
        chk("rm_out_tvalid", 128'(axis_out_tvalid), 128'(0));
        chk("rm_in_tready", 128'(in_tready), 128'(0));
        chk("rm_grant", 128'(grant), 128'(0));
        @(posedge clk);
        #2;
        resetn = 1'b1;
        enqueue(0, 2, DW'(16'h4600), 0);
        enqueue(1, 2, DW'(16'h4700), 0);
        schedule();
        wait_grant("rm_first_grant", 2'b01, 20);
        wait_drain("rm_drain", 100);
        chk_cnt("rm_pkt_count");

        // Randomized traffic: lengths 1..5, tvalid gaps, random backpressure.
        do_reset();
        gaps_en  = 1;
        rdy_mode = 1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NUM_IN; i++) begin
                int np;
                np = $urandom_range(3, 6);
                for (int p = 0; p < np; p++) enqueue(i, $urandom_range(1, 5), '0, 1);
            end
            schedule();
            wait_drain("rand_drain", 4000);
            chk_cnt("rand_pkt_count");
        end
        rdy_mode        = 0;
        axis_out_tready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Shares one downstream AXI stream (the DCMAC transmit path) between NUM_IN upstream packet sources.
- Arbitration is packet-granular round-robin: a grant is held from the first beat to the tlast beat, so packets are never interleaved.
- A 2-deep register stage on the output breaks timing between the mux and the MAC.

Parameters:
- NUM_IN, 2, number of requesting input streams (2..4).
- DW, 512, tdata width.
- KW, 64, tkeep width (DW/8).
- UW, 1, tuser width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- enable  in  1  1 = new grants allowed; 0 = finish the current packet, then hold idle.
- in_tdata  in  NUM_IN*DW  flattened inputs; input i occupies bits [i*DW +: DW].
- in_tkeep  in  NUM_IN*KW  flattened, same layout.
- in_tuser  in  NUM_IN*UW  flattened, same layout.
- in_tlast  in  NUM_IN  one bit per input.
- in_tvalid  in  NUM_IN  one bit per input.
- in_tready  out  NUM_IN  one bit per input.
- axis_out_tdata/tkeep/tuser/tlast  out  DW/KW/UW/1  output stream.
- axis_out_tvalid  out  1.
- axis_out_tready  in  1.
- grant  out  NUM_IN  one-hot current owner; 0 when idle.
- busy  out  1  high while in S_GRANT or while the output stage holds data.
- pkt_count  out  NUM_IN*32  per-input completed-packet counters; tied 0 unless the feature macro is defined.

Behaviour:
- Reset: state=S_IDLE, grant=0, last_grant=NUM_IN-1 (so input 0 wins first), in_tready=0, axis_out_tvalid=0, output stage empty, busy=0, pkt_count=0.
- S_IDLE:
  - if enable and any in_tvalid, pick the first valid input searching from last_grant+1 with wrap-around.
  - Register grant (one-hot) and go to S_GRANT. Arbitration costs exactly 1 cycle; in_tready stays 0 in S_IDLE.
- S_GRANT:
  - in_tready[g] = stage_in_ready; all other in_tready bits = 0.
  - The selected input's tdata/tkeep/tuser/tlast/tvalid drive the output stage input.
  - On an accepted beat (in_tvalid[g] & in_tready[g]) with tlast=1: last_grant<=g, grant<=0, state<=S_IDLE.
- Throughput: 1-beat bubble between packets. Back-to-back packets from different inputs therefore take 1 idle cycle at the stage input.
- Output stage:
  - 2-entry FIFO; stage_in_ready = count!=2; axis_out_tvalid = count!=0.
  - Latency from accepted input beat to axis_out_tvalid is 1 cycle.
  - Full throughput is sustained while axis_out_tready stays high.
  - Simultaneous push and pop leaves the count unchanged.
- enable:
  - Sampled only in S_IDLE; deasserting mid-packet has no effect until tlast.
  - With enable=0, busy drops once the stage drains.
- The granted input dropping tvalid mid-packet: the grant is held and the arbiter waits; there is no timeout.
- Single-beat packets (tlast on the first beat) are legal and take 2 cycles per packet from the same input.
- last_grant wraps NUM_IN-1 -> 0.
- Reset mid-packet:
  - Stage contents are discarded and the packet is truncated downstream. The caller must reset the MAC as well.
  - After reset, arbitration restarts at input 0.
- tkeep/tuser are passed through unchanged; no validation is done.

Optional Feature:
- Macro: AXIS_ARB_PKT_COUNT_EN.
- Defined:
  - each input has a 32-bit counter, incremented on its accepted tlast beat, wrapping 0xFFFFFFFF -> 0.
  - Counters are cleared by reset only and exposed on pkt_count[i*32 +: 32].
- Undefined: no counter logic; pkt_count is driven to 0.

Decomposition:
- Shared package axis_arb_pkg holds:
  - state encoding S_IDLE=1'b0, S_GRANT=1'b1;
  - function rr_pick(valid, last) returning a one-hot result;
  - constant CNT_W=32.
- One sub-module: axis_out_stage (2-entry register FIFO with DW/KW/UW parameters), instantiated once on the output.

Test Plan:
- Single source: input 0 sends a 4-beat packet, tdata 1..4, axis_out_tready=1 -> grant=01 on cycle 1 after tvalid; output beats 1..4 on consecutive cycles starting 1 cycle after acceptance; tlast on beat 4; grant returns to 0.
- Contention: both inputs continuously valid with 3-beat packets -> output order in0,in1,in0,in1; no interleaving inside a packet; 1 idle input cycle between packets.
- Backpressure: axis_out_tready toggles 1,0,0,1 during a 5-beat packet -> the stage fills to 2, in_tready drops to 0, all 5 beats arrive in order, none are lost or duplicated.
- enable=0 asserted mid-packet on input 1 -> the packet completes through tlast; afterwards grant stays 0 despite in_tvalid=11; busy falls after the stage drains; raising enable resumes with input 0.
- Reset asserted on the 2nd beat of a packet -> next cycle axis_out_tvalid=0, in_tready=0, grant=0; the first post-reset grant goes to input 0.
- With AXIS_ARB_PKT_COUNT_EN defined: 3 packets from in0 and 2 from in1 -> pkt_count reads in0=3, in1=2. Without the macro, pkt_count reads 0.
